// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    SADD = 2'b10,
    SSUB = 2'b11
  } alu_mode_e;

  localparam int GROUP_W = 4;
  localparam int MAX_W   = 256;

  // Clamp value for a saturated result: most negative if sign=1, else most positive.
  function automatic logic [MAX_W-1:0] sat_value(input logic sign, input int width);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width - 1)       v[i] = ~sign;
      else if (i == width - 1) v[i] = sign;
    end
    return v;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: local sum plus group generate/propagate for the slice LCU.
module cla_group4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_g,
  output logic       o_p
);

  logic [3:0] w_g, w_p, w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ w_c;
  assign o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_p   = &w_p;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA add/sub: STAGES slices of WIDTH/STAGES bits, registered slice carries,
// global stall on backpressure, saturation and flags resolved after the last stage.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVFL,
  output logic             ZERO
);

  localparam int S  = WIDTH / STAGES;
  localparam int NG = S / GROUP_W;

  logic             w_en;
  logic [WIDTH-1:0] w_bx0;
  logic             w_cx0;

  // Single advance enable: the whole pipe moves or the whole pipe holds.
  assign w_en     = !OUT_VALID || OUT_READY;
  assign IN_READY = w_en;

  assign w_bx0 = MODE[0] ? ~B : B;
  assign w_cx0 = CIN ^ MODE[0];

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] w_a, w_bx, w_sum_in, w_sum_nxt;
      logic             w_cin, w_vld_in;
      alu_mode_e        w_mode;

      logic [WIDTH-1:0] r_a, r_bx, r_sum;
      logic             r_c, r_vld;
      alu_mode_e        r_mode;

      if (k == 0) begin : g_in
        assign w_a      = A;
        assign w_bx     = w_bx0;
        assign w_cin    = w_cx0;
        assign w_sum_in = '0;
        assign w_mode   = alu_mode_e'(MODE);
        assign w_vld_in = IN_VALID;
      end else begin : g_skew
        assign w_a      = g_stage[k-1].r_a;
        assign w_bx     = g_stage[k-1].r_bx;
        assign w_cin    = g_stage[k-1].r_c;
        assign w_sum_in = g_stage[k-1].r_sum;
        assign w_mode   = g_stage[k-1].r_mode;
        assign w_vld_in = g_stage[k-1].r_vld;
      end

      logic [NG-1:0] w_gg, w_gp;
      logic [NG:0]   w_gc;
      logic [S-1:0]  w_ssum;

      for (genvar g = 0; g < NG; g++) begin : g_grp
        cla_group4 u_grp (
          .i_a   (w_a [k*S + g*GROUP_W +: GROUP_W]),
          .i_b   (w_bx[k*S + g*GROUP_W +: GROUP_W]),
          .i_cin (w_gc[g]),
          .o_sum (w_ssum[g*GROUP_W +: GROUP_W]),
          .o_g   (w_gg[g]),
          .o_p   (w_gp[g])
        );
      end

      // Slice lookahead unit: each group carry-in formed directly from G/P and the slice carry-in.
      always_comb begin
        logic acc;
        w_gc    = '0;
        w_gc[0] = w_cin;
        for (int g = 1; g <= NG; g++) begin
          acc = w_cin;
          for (int j = 0; j < g; j++) acc = w_gg[j] | (w_gp[j] & acc);
          w_gc[g] = acc;
        end
      end

      always_comb begin
        w_sum_nxt            = w_sum_in;
        w_sum_nxt[k*S +: S]  = w_ssum;
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_vld  <= 1'b0;
          r_a    <= '0;
          r_bx   <= '0;
          r_sum  <= '0;
          r_c    <= 1'b0;
          r_mode <= ADD;
        end else if (w_en) begin
          r_vld  <= w_vld_in;
          r_a    <= w_a;
          r_bx   <= w_bx;
          r_sum  <= w_sum_nxt;
          r_c    <= w_gc[NG];
          r_mode <= w_mode;
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] w_raw, w_a_l, w_bx_l, w_sat;
  logic             w_ovfl, w_sat_en;
  alu_mode_e        w_mode_l;

  assign w_raw    = g_stage[STAGES-1].r_sum;
  assign w_a_l    = g_stage[STAGES-1].r_a;
  assign w_bx_l   = g_stage[STAGES-1].r_bx;
  assign w_mode_l = g_stage[STAGES-1].r_mode;

  assign w_ovfl   = (w_a_l[WIDTH-1] == w_bx_l[WIDTH-1]) && (w_raw[WIDTH-1] != w_a_l[WIDTH-1]);
  assign w_sat_en = w_ovfl && ((w_mode_l == SADD) || (w_mode_l == SSUB));
  assign w_sat    = WIDTH'(sat_value(w_a_l[WIDTH-1], WIDTH));

  assign OUT_VALID = g_stage[STAGES-1].r_vld;
  assign SUM       = w_sat_en ? w_sat : w_raw;
  assign COUT      = g_stage[STAGES-1].r_c;
  assign OVFL      = w_ovfl;
  assign ZERO      = (SUM == '0);

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench: the driver queues expected results on accept, a monitor pops on each output beat.
module tb_pipelined_cla_addsub;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
    logic        zero;
  } exp_t;

  logic             CLK, RST, IN_VALID, IN_READY, CIN, OUT_VALID, OUT_READY, COUT, OVFL, ZERO;
  logic [WIDTH-1:0] A, B, SUM;
  logic [1:0]       MODE;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN), .MODE(MODE),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .SUM(SUM), .COUT(COUT), .OVFL(OVFL), .ZERO(ZERO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_holds  = 0;
  bit   rand_rdy = 0;
  int   hold_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Independent golden model using plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [1:0] mode);
    exp_t e;
    int ua, ub, uv, sa, sb, sv, c;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = cin ? 1 : 0;
    if (mode[0]) begin
      uv = ua - ub - c;
      sv = sa - sb - c;
      e.cout = (uv >= 0);
    end else begin
      uv = ua + ub + c;
      sv = sa + sb + c;
      e.cout = (uv > 65535);
    end
    e.sum  = uv[15:0];
    e.ovfl = (sv > 32767) || (sv < -32768);
    if (mode[1] && e.ovfl) e.sum = (sv > 32767) ? 16'h7FFF : 16'h8000;
    e.zero = (e.sum == 16'h0000);
    return e;
  endfunction

  task automatic drive_ready();
    if (rand_rdy) OUT_READY = 1'($urandom_range(0, 1));
    else if (hold_left > 0) begin
      OUT_READY = 1'b0;
      hold_left--;
    end else OUT_READY = 1'b1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [1:0] mode, input exp_t e);
    int  waitc = 0;
    bit  done  = 0;
    while (!done) begin
      @(negedge CLK);
      drive_ready();
      IN_VALID = 1'b1; A = a; B = b; CIN = cin; MODE = mode;
      #1;
      if (IN_READY) begin
        @(posedge CLK);
        sbq.push_back(e);
        #1;
        IN_VALID = 1'b0;
        done = 1;
      end else if (++waitc > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: IN_READY stuck at %b required 1", IN_READY);
        IN_VALID = 1'b0;
        done = 1;
      end
    end
  endtask

  task automatic drain();
    int c = 0;
    while (sbq.size() != 0 && c < 200) begin
      @(negedge CLK);
      drive_ready();
      IN_VALID = 1'b0;
      c++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // Monitor: samples mid-cycle, after all driver changes have settled.
  bit   held = 0;
  logic [19:0] held_vals;
  always @(negedge CLK) begin
    exp_t e;
    #2;
    if (RST) held = 0;
    else begin
      if (held) chk("hold_stable", {OUT_VALID, SUM, COUT, OVFL, ZERO}, held_vals);
      if (OUT_VALID && !OUT_READY) begin
        chk("in_ready_low", IN_READY, 0);
        held      = 1;
        held_vals = {OUT_VALID, SUM, COUT, OVFL, ZERO};
        n_holds++;
      end else held = 0;
      if (OUT_VALID && OUT_READY) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got SUM=%h with empty scoreboard", SUM);
        end else begin
          e = sbq.pop_front();
          chk("result", {SUM, COUT, OVFL, ZERO}, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] st_a [6] = '{16'h0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
  logic [15:0] st_s [6] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656};

  initial begin
    int holds0;
    logic [15:0] ra, rb;
    logic        rc;
    logic [1:0]  rm;
    IN_VALID = 0; A = 0; B = 0; CIN = 0; MODE = 0; OUT_READY = 1; RST = 1;
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_cout", COUT, 0);
    chk("rst_ovfl", OVFL, 0);
    chk("rst_zero", ZERO, 1);
    chk("rst_in_ready", IN_READY, 1);
    RST = 0;

    // First beat doubles as the latency check.
    send(16'hFFFF, 16'h0001, 0, 2'b00, '{16'h0000, 1'b1, 1'b0, 1'b1});
    chk("lat_edge1", OUT_VALID, 0);
    @(posedge CLK); #1;
    chk("lat_edge2", OUT_VALID, 1);

    send(16'h7FFF, 16'h0001, 0, 2'b00, '{16'h8000, 1'b0, 1'b1, 1'b0});
    send(16'h7FFF, 16'h0001, 0, 2'b10, '{16'h7FFF, 1'b0, 1'b1, 1'b0});
    send(16'h0000, 16'h0001, 0, 2'b01, '{16'hFFFF, 1'b0, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 0, 2'b11, '{16'h8000, 1'b1, 1'b1, 1'b0});
    send(16'h0005, 16'h0003, 1, 2'b01, '{16'h0001, 1'b1, 1'b0, 1'b0});
    send(16'h00FF, 16'h0001, 0, 2'b00, '{16'h0100, 1'b0, 1'b0, 1'b0});
    send(16'h1234, 16'h4321, 1, 2'b00, '{16'h5556, 1'b0, 1'b0, 1'b0});
    send(16'h0003, 16'h0005, 0, 2'b11, '{16'hFFFE, 1'b0, 1'b0, 1'b0});
    send(16'h8000, 16'h8000, 0, 2'b10, '{16'h8000, 1'b1, 1'b1, 1'b0});
    send(16'h8000, 16'h8000, 0, 2'b00, '{16'h0000, 1'b1, 1'b1, 1'b1});
    drain();

    // Back-to-back stream with a 3-cycle output stall in the middle.
    holds0 = n_holds;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) hold_left = 3;
      send(st_a[i], 16'h0101, 0, 2'b00, '{st_s[i], 1'b0, 1'b0, 1'b0});
    end
    drain();
    chk("hold_cycles", n_holds - holds0, 3);

    // Reset with two beats in flight.
    send(16'h1000, 16'h0001, 0, 2'b00, '{16'h1001, 1'b0, 1'b0, 1'b0});
    send(16'h2000, 16'h0002, 0, 2'b00, '{16'h2002, 1'b0, 1'b0, 1'b0});
    chk("inflight_valid", OUT_VALID, 1);
    RST = 1;
    sbq.delete();
    #1;
    chk("async_rst_valid", OUT_VALID, 0);
    chk("async_rst_sum", SUM, 0);
    chk("async_rst_zero", ZERO, 1);
    repeat (2) @(negedge CLK);
    RST = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      chk("no_stale_beat", OUT_VALID, 0);
    end
    chk("post_rst_ready", IN_READY, 1);

    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      send(ra, rb, rc, rm, model(ra, rb, rc, rm));
    end
    rand_rdy = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
